pn_burst_ctrl: RTL and testbench
================================

PN_BURST_CTRL -- requirements
Module: pn_burst_ctrl

Interface
REQ-001 Parameter LEN_W, default 8: width of burst_len and of the internal chip counter.
REQ-002 sys_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 sys_rst_n  input  1  asynchronous, active-low reset; one clock domain only.
REQ-004 start  input  1  request a burst; sampled only in IDLE.
REQ-005 seed  input  4  LFSR initial state; captured with start.
REQ-006 burst_len  input  LEN_W  number of chips in the burst; captured with start.
REQ-007 hold  input  1  pause chip generation while high in RUN.
REQ-008 abort  input  1  terminate the burst immediately.
REQ-009 busy  output  1  high in LOAD, RUN and DONE.
REQ-010 chip_out  output  1  current PN chip, registered.
REQ-011 chip_valid  output  1  chip_out carries a new chip this cycle, registered.
REQ-012 period_tick  output  1  high with every 15th chip of a burst.
REQ-013 done  output  1  one-cycle burst-complete pulse.
REQ-014 seed_err  output  1  one-cycle pulse: start rejected, seed == 0.
REQ-015 lfsr_state  output  4  current LFSR register contents.

Function
REQ-016 FSM states: IDLE, LOAD, RUN, DONE; state register decoded for busy and done (glitch-free).
REQ-017 IDLE, start=1, seed=0: seed_err=1 next cycle, stay IDLE, nothing captured.
REQ-018 IDLE, start=1, seed!=0, burst_len=0: go to DONE directly; no chips emitted.
REQ-019 IDLE, start=1, seed!=0, burst_len!=0: capture seed and burst_len, go to LOAD.
REQ-020 LOAD (exactly 1 cycle): lfsr_state<=seed, chip counter<=0, period counter<=0, go to RUN; hold ignored.
REQ-021 RUN, hold=0: chip_out<=lfsr_state[0], chip_valid<=1, lfsr_state<={lfsr_state[0]^lfsr_state[3], lfsr_state[3:1]}, chip counter +1.
REQ-022 RUN, hold=1: chip_valid<=0; lfsr_state, counters, chip_out all frozen.
REQ-023 Edge that emits chip number burst_len moves RUN->DONE; done and that last chip_valid are high in the same cycle.
REQ-024 DONE lasts exactly 1 cycle, then IDLE; chip_valid<=0 on exit.
REQ-025 Latency: first chip_valid rises on the 2nd rising edge after the edge sampling start (hold=0).
REQ-026 period_tick: 4-bit period counter increments per emitted chip, wraps 14->0; period_tick high alongside chips 15, 30, 45, ...
REQ-027 abort in LOAD or RUN: next state IDLE, chip_valid<=0, no done pulse; abort beats hold and burst completion in the same cycle.
REQ-028 abort in IDLE or DONE: ignored.
REQ-029 start while busy: ignored, not queued.
REQ-030 Chip counter is LEN_W bits; burst_len = 2^LEN_W-1 completes without overflow.
REQ-031 lfsr_state holds its value in IDLE after a burst; cleared only by reset.

Reset
REQ-032 sys_rst_n low: state=IDLE; lfsr_state=0; all counters=0; chip_out, chip_valid, period_tick, done, seed_err, busy=0; takes effect immediately, no clock needed.
REQ-033 Reset asserted mid-burst aborts the burst with no done pulse; first action after release is a fresh start.

Verification
REQ-034 seed=4'b0110, burst_len=8, hold=0 -> chips 0,1,1,0,0,1,0,0; done coincides with 8th chip_valid; busy low one cycle later.
REQ-035 seed=4'b0001, burst_len=30 -> period_tick high with chips 15 and 30 only; chip 16 equals chip 1 (period 15).
REQ-036 seed=0, start=1 in IDLE -> seed_err pulse 1 cycle; busy, chip_valid stay 0.
REQ-037 burst_len=10, hold high 3 cycles after chip 4 -> no chip_valid for 3 cycles, chips 5..10 continue the same sequence, done with chip 10.
REQ-038 abort one cycle after chip 3 -> chip_valid low next cycle, IDLE, no done; start pulse during that burst ignored.
REQ-039 sys_rst_n low during RUN -> all outputs 0 immediately; after release, new start with burst_len=0 -> done pulse, zero chips.

Source files
------------

// File: rtl/pn_burst_ctrl.sv
// PN burst controller: emits a burst of chips from a 4-bit maximal-length LFSR
// (period 15), with hold/abort control and a tick on every 15th chip.
//
// state | meaning
// IDLE  | waiting for start; LFSR keeps its last contents
// LOAD  | one cycle: seed copied into LFSR, counters cleared
// RUN   | one chip per cycle unless hold is high
// DONE  | one cycle: done pulse, coincides with the last chip_valid
module pn_burst_ctrl #(
  parameter int LEN_W = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             start,
  input  logic [3:0]       seed,
  input  logic [LEN_W-1:0] burst_len,
  input  logic             hold,
  input  logic             abort,
  output logic             busy,
  output logic             chip_out,
  output logic             chip_valid,
  output logic             period_tick,
  output logic             done,
  output logic             seed_err,
  output logic [3:0]       lfsr_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [3:0]         seed_q, seed_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         per_q, per_d;
  logic [3:0]         lfsr_q, lfsr_d;
  logic               chip_q, chip_d;
  logic               valid_q, valid_d;
  logic               tick_q, tick_d;
  logic               seed_err_q, seed_err_d;

  logic               last_chip;
  logic               per_wrap;

  // Comparing against len-1 keeps the counter inside LEN_W bits even for
  // the maximum burst length.
  assign last_chip = (cnt_q == (len_q - LEN_W'(1)));
  assign per_wrap  = (per_q == 4'd14);

  always_comb begin
    state_d    = state_q;
    seed_d     = seed_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    per_d      = per_q;
    lfsr_d     = lfsr_q;
    chip_d     = chip_q;
    valid_d    = 1'b0;
    tick_d     = 1'b0;
    seed_err_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (seed == 4'd0) begin
            seed_err_d = 1'b1;
          end else if (burst_len == '0) begin
            state_d = ST_DONE;
          end else begin
            seed_d  = seed;
            len_d   = burst_len;
            state_d = ST_LOAD;
          end
        end
      end

      ST_LOAD: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          lfsr_d  = seed_q;
          cnt_d   = '0;
          per_d   = 4'd0;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (!hold) begin
          chip_d  = lfsr_q[0];
          valid_d = 1'b1;
          lfsr_d  = {lfsr_q[0] ^ lfsr_q[3], lfsr_q[3:1]};
          cnt_d   = cnt_q + LEN_W'(1);
          tick_d  = per_wrap;
          per_d   = per_wrap ? 4'd0 : per_q + 4'd1;
          if (last_chip) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= ST_IDLE;
      seed_q     <= 4'd0;
      len_q      <= '0;
      cnt_q      <= '0;
      per_q      <= 4'd0;
      lfsr_q     <= 4'd0;
      chip_q     <= 1'b0;
      valid_q    <= 1'b0;
      tick_q     <= 1'b0;
      seed_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      seed_q     <= seed_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      per_q      <= per_d;
      lfsr_q     <= lfsr_d;
      chip_q     <= chip_d;
      valid_q    <= valid_d;
      tick_q     <= tick_d;
      seed_err_q <= seed_err_d;
    end
  end

  // busy and done come straight from the state register, so they cannot glitch.
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign chip_out    = chip_q;
  assign chip_valid  = valid_q;
  assign period_tick = tick_q;
  assign seed_err    = seed_err_q;
  assign lfsr_state  = lfsr_q;

endmodule

// File: tb/tb_pn_burst_ctrl.sv
// Self-checking bench for pn_burst_ctrl: directed and randomized bursts checked
// against a transaction-level model of the PN sequence and burst timing.
module tb_pn_burst_ctrl;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b1;
  logic       start = 1'b0;
  logic [3:0] seed = 4'd0;
  logic [7:0] burst_len = 8'd0;
  logic       hold = 1'b0;
  logic       abort = 1'b0;
  logic       busy, chip_out, chip_valid, period_tick, done, seed_err;
  logic [3:0] lfsr_state;

  int errors = 0;
  int checks = 0;
  logic got [0:255];

  pn_burst_ctrl #(.LEN_W(8)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .start      (start),
    .seed       (seed),
    .burst_len  (burst_len),
    .hold       (hold),
    .abort      (abort),
    .busy       (busy),
    .chip_out   (chip_out),
    .chip_valid (chip_valid),
    .period_tick(period_tick),
    .done       (done),
    .seed_err   (seed_err),
    .lfsr_state (lfsr_state)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Shift right, new MSB is bit0 xor bit3.
  function automatic logic [3:0] lfsr_step(input logic [3:0] s);
    int v;
    v = int'(s);
    return 4'((((v ^ (v >> 3)) & 1) << 3) | (v >> 1));
  endfunction

  // hold_mode: 0 none, 1 random, 2 three-cycle hold after chip 4.
  // abort_after: 0 none, else abort right after that chip.
  task automatic do_burst(input logic [3:0] sd, input int len, input int hold_mode,
                          input int abort_after);
    logic [3:0] m;
    logic       exp_chip;
    int         k;
    int         held;
    seed      = sd;
    burst_len = len[7:0];
    start     = 1'b1;
    hold      = 1'b0;
    abort     = 1'b0;
    tick();
    chk("load_busy", 32'(busy), 32'd1);
    chk("load_valid", 32'(chip_valid), 32'd0);
    chk("load_done", 32'(done), 32'd0);
    start = 1'b0;
    hold  = (hold_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    tick();
    chk("run_lfsr_seed", 32'(lfsr_state), 32'(sd));
    chk("run_first_valid", 32'(chip_valid), 32'd0);
    m    = sd;
    k    = 0;
    held = 0;
    while (k < len) begin
      start = 1'($urandom_range(0, 1));
      seed  = 4'($urandom_range(0, 15));
      if (hold_mode == 1) hold = ($urandom_range(0, 3) == 0);
      else if (hold_mode == 2) hold = (k == 4 && held < 3);
      else hold = 1'b0;
      if (abort_after != 0 && k == abort_after) begin
        abort = 1'b1;
        tick();
        chk("abort_valid", 32'(chip_valid), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        abort = 1'b0;
        start = 1'b0;
        hold  = 1'b0;
        tick();
        chk("abort_idle_busy", 32'(busy), 32'd0);
        chk("abort_idle_done", 32'(done), 32'd0);
        chk("abort_idle_valid", 32'(chip_valid), 32'd0);
        return;
      end
      tick();
      if (hold) begin
        held++;
        chk("hold_valid", 32'(chip_valid), 32'd0);
        chk("hold_lfsr", 32'(lfsr_state), 32'(m));
      end else begin
        exp_chip = m[0];
        m = lfsr_step(m);
        k++;
        got[k] = chip_out;
        chk("chip_valid", 32'(chip_valid), 32'd1);
        chk("chip_out", 32'(chip_out), 32'(exp_chip));
        chk("period_tick", 32'(period_tick), 32'(k % 15 == 0));
        chk("done_at_last", 32'(done), 32'(k == len));
        chk("lfsr_after_chip", 32'(lfsr_state), 32'(m));
        chk("busy_run", 32'(busy), 32'd1);
      end
    end
    start = 1'b0;
    hold  = 1'b0;
    tick();
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_done", 32'(done), 32'd0);
    chk("end_valid", 32'(chip_valid), 32'd0);
    chk("end_tick", 32'(period_tick), 32'd0);
    tick();
    chk("idle_lfsr_hold", 32'(lfsr_state), 32'(m));
  endtask

  initial begin
    logic [7:0] exp034;
    logic [3:0] rs;
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(chip_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_lfsr", 32'(lfsr_state), 32'd0);
    chk("rst_seed_err", 32'(seed_err), 32'd0);
    chk("rst_tick", 32'(period_tick), 32'd0);
    chk("rst_chip", 32'(chip_out), 32'd0);
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    tick();

    // Known 8-chip sequence from seed 0110
    do_burst(4'b0110, 8, 0, 0);
    exp034 = 8'b0110_0100;
    for (int i = 1; i <= 8; i++) chk("seq_0110", 32'(got[i]), 32'(exp034[8-i]));

    // Period 15: ticks at chips 15 and 30, sequence repeats
    do_burst(4'b0001, 30, 0, 0);
    chk("period_repeat", 32'(got[16]), 32'(got[1]));
    chk("period_repeat2", 32'(got[30]), 32'(got[15]));

    // Zero seed rejected
    seed  = 4'd0;
    burst_len = 8'd5;
    start = 1'b1;
    tick();
    chk("seed_err_pulse", 32'(seed_err), 32'd1);
    chk("seed_err_busy", 32'(busy), 32'd0);
    chk("seed_err_valid", 32'(chip_valid), 32'd0);
    start = 1'b0;
    tick();
    chk("seed_err_clear", 32'(seed_err), 32'd0);
    chk("seed_err_idle", 32'(busy), 32'd0);

    // Hold for three cycles after chip 4
    do_burst(4'b1011, 10, 2, 0);

    // Abort after chip 3 (random start pulses during the burst are ignored)
    do_burst(4'b0101, 12, 0, 3);

    // Randomized bursts with random hold and ignored start pulses
    for (int n = 0; n < 6; n++) begin
      rs = 4'($urandom_range(1, 15));
      do_burst(rs, $urandom_range(1, 40), 1, 0);
    end

    // Maximum length burst
    do_burst(4'($urandom_range(1, 15)), 255, 0, 0);

    // Reset in the middle of a burst
    seed = 4'd5;
    burst_len = 8'd20;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_valid", 32'(chip_valid), 32'd0);
    chk("midrst_chip", 32'(chip_out), 32'd0);
    chk("midrst_lfsr", 32'(lfsr_state), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_tick", 32'(period_tick), 32'd0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    seed = 4'd3;
    burst_len = 8'd0;
    start = 1'b1;
    tick();
    chk("zero_len_done", 32'(done), 32'd1);
    chk("zero_len_valid", 32'(chip_valid), 32'd0);
    chk("zero_len_busy", 32'(busy), 32'd1);
    start = 1'b0;
    tick();
    chk("zero_len_end_done", 32'(done), 32'd0);
    chk("zero_len_end_busy", 32'(busy), 32'd0);
    chk("zero_len_end_valid", 32'(chip_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
